// File: rtl/nexys_starship_pkg.sv
// Shared encodings for the starship repair bank and its stations.
package nexys_starship_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMING = 2'd1,
    ST_ARMED  = 2'd2,
    ST_BROKEN = 2'd3
  } station_state_t;

  typedef enum logic [1:0] {
    INIT = 2'b01,
    PLAY = 2'b10
  } bank_state_t;

  localparam int REPAIR_COUNT_W = 8;
  localparam logic [REPAIR_COUNT_W-1:0] REPAIR_COUNT_MAX = '1;

endpackage

// File: rtl/nexys_starship_station.sv
// One ship station: arming delay, break on grant, latched repair combo and repair deadline.
module nexys_starship_station
  import nexys_starship_pkg::*;
#(
  parameter int COMBO_W      = 4,
  parameter int ARM_TICKS    = 8,
  parameter int REPAIR_TICKS = 32
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic               clear,
  input  logic               tick,
  input  logic               grant,
  input  logic               repair_ok,
  input  logic               force_repair,
  input  logic [COMBO_W-1:0] random_hex,
  output logic               is_armed,
  output logic               is_broken,
  output logic               deadline,
  output logic [COMBO_W-1:0] combo
);

  localparam int MAX_T = (ARM_TICKS > REPAIR_TICKS) ? ARM_TICKS : REPAIR_TICKS;
  localparam int CNT_W = $clog2(MAX_T + 1);
  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPAIR_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REPAIR_TICKS);

  station_state_t     state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [COMBO_W-1:0] combo_n;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      combo <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      combo <= combo_n;
    end
  end

  // A repair takes precedence over the deadline tick arriving in the same cycle.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    combo_n  = combo;
    deadline = 1'b0;
    if (clear) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      combo_n = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_n = ST_ARMING;
            cnt_n   = '0;
          end
        end
        ST_ARMING: begin
          if (tick) begin
            if (cnt == ARM_LAST) begin
              state_n = ST_ARMED;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        ST_ARMED: begin
          if (grant) begin
            state_n = ST_BROKEN;
            cnt_n   = '0;
            combo_n = random_hex;
          end
        end
        ST_BROKEN: begin
          if (repair_ok || force_repair) begin
            state_n = ST_ARMING;
            cnt_n   = '0;
            combo_n = '0;
          end else if (tick && cnt != REP_MAX) begin
            cnt_n    = cnt + 1'b1;
            deadline = (cnt == REP_LAST);
          end
        end
      endcase
    end
  end

  assign is_armed  = (state == ST_ARMED);
  assign is_broken = (state == ST_BROKEN);

endmodule

// File: rtl/nexys_starship_repair_bank.sv
// Bank of repair stations: play/init control, break arbitration, repair scoring and overdue flag.
module nexys_starship_repair_bank
  import nexys_starship_pkg::*;
#(
  parameter int NUM_STATIONS = 4,
  parameter int COMBO_W      = 4,
  parameter int ARM_TICKS    = 8,
  parameter int REPAIR_TICKS = 32,
  parameter int MAX_BROKEN   = 2,
  localparam int SEL_W = (NUM_STATIONS > 1) ? $clog2(NUM_STATIONS) : 1
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            timer_tick,
  input  logic                            play_flag,
  input  logic                            gameover_ctrl,
  input  logic [NUM_STATIONS-1:0]         break_random,
  input  logic [COMBO_W-1:0]              random_hex,
  input  logic [COMBO_W-1:0]              hex_combo,
  input  logic [SEL_W-1:0]                sel,
  input  logic                            submit,
  input  logic                            override,
  output logic                            q_Init,
  output logic                            q_Play,
  output logic [NUM_STATIONS-1:0]         broken,
  output logic [NUM_STATIONS*COMBO_W-1:0] combo_flat,
  output logic                            overdue,
  output logic                            bad_try,
  output logic [REPAIR_COUNT_W-1:0]       repair_count
);

  localparam int BCNT_W = $clog2(NUM_STATIONS + 1);
  localparam logic [BCNT_W-1:0] MAX_B = BCNT_W'(MAX_BROKEN);

  bank_state_t             bank_state, bank_next;
  logic                    active, start, repaired, wrong_try;
  logic [BCNT_W-1:0]       broken_cnt;
  logic [NUM_STATIONS-1:0] armed, eligible, grant, sel_hit, match;
  logic [NUM_STATIONS-1:0] repair_ok, force_rep, deadline;

  assign active = (bank_state == PLAY) && !gameover_ctrl;
  assign start  = (bank_state == INIT) && play_flag && !gameover_ctrl;

  for (genvar i = 0; i < NUM_STATIONS; i++) begin : g_station
    localparam logic [SEL_W-1:0] IDX = SEL_W'(i);
    logic [COMBO_W-1:0] combo_i;

    assign sel_hit[i] = (sel == IDX);
    assign match[i]   = (hex_combo == combo_i);
    assign combo_flat[i*COMBO_W +: COMBO_W] = combo_i;

    nexys_starship_station #(
      .COMBO_W      (COMBO_W),
      .ARM_TICKS    (ARM_TICKS),
      .REPAIR_TICKS (REPAIR_TICKS)
    ) u_station (
      .Clk          (Clk),
      .Reset        (Reset),
      .start        (start),
      .clear        (gameover_ctrl),
      .tick         (timer_tick),
      .grant        (grant[i]),
      .repair_ok    (repair_ok[i]),
      .force_repair (force_rep[i]),
      .random_hex   (random_hex),
      .is_armed     (armed[i]),
      .is_broken    (broken[i]),
      .deadline     (deadline[i]),
      .combo        (combo_i)
    );
  end

  always_comb begin
    broken_cnt = '0;
    for (int i = 0; i < NUM_STATIONS; i++) begin
      broken_cnt = broken_cnt + BCNT_W'(broken[i]);
    end
  end

  // Lowest-index armed requester wins; at most one new break per cycle.
  assign eligible  = armed & break_random;
  assign grant     = (active && broken_cnt < MAX_B) ? (eligible & (~eligible + NUM_STATIONS'(1))) : '0;
  assign force_rep = {NUM_STATIONS{active & override}} & broken & sel_hit;
  assign repair_ok = {NUM_STATIONS{active & submit & ~override}} & broken & sel_hit & match;
  assign repaired  = |(repair_ok | force_rep);
  assign wrong_try = active && submit && !override && |(broken & sel_hit & ~match);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) bank_state <= INIT;
    else        bank_state <= bank_next;
  end

  always_comb begin
    bank_next = bank_state;
    case (bank_state)
      INIT:    if (start) bank_next = PLAY;
      PLAY:    if (gameover_ctrl) bank_next = INIT;
      default: bank_next = INIT;
    endcase
  end

  // Score and overdue survive gameover so the display can show them; a new game clears both.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      overdue      <= 1'b0;
      bad_try      <= 1'b0;
      repair_count <= '0;
    end else begin
      bad_try <= wrong_try;
      if (start) begin
        repair_count <= '0;
        overdue      <= 1'b0;
      end else if (active) begin
        if (repaired && repair_count != REPAIR_COUNT_MAX) repair_count <= repair_count + 1'b1;
        if (|deadline) overdue <= 1'b1;
      end
    end
  end

  assign q_Init = (bank_state == INIT);
  assign q_Play = (bank_state == PLAY);

endmodule

// File: tb/tb_nexys_starship_repair_bank.sv
// Self-checking bench for the repair bank: directed table, corner sequences and randomized model run.
module tb_nexys_starship_repair_bank;

  localparam int N    = 4;
  localparam int CW   = 4;
  localparam int ARM  = 8;
  localparam int REP  = 32;
  localparam int MAXB = 2;

  typedef struct {
    logic          tick, play, gover;
    logic [N-1:0]  brk;
    logic [CW-1:0] rhex, hex;
    logic [1:0]    sel;
    logic          sub, ovr;
  } stim_t;

  typedef struct {
    stim_t           in;
    logic [N-1:0]    exp_broken;
    logic [N*CW-1:0] exp_combo;
    logic            exp_bad;
    logic [7:0]      exp_count;
  } vector_t;

  logic            Clk = 1'b0;
  logic            Reset = 1'b0;
  logic            timer_tick, play_flag, gameover_ctrl, submit, override;
  logic [N-1:0]    break_random;
  logic [CW-1:0]   random_hex, hex_combo;
  logic [1:0]      sel;
  logic            q_Init, q_Play, overdue, bad_try;
  logic [N-1:0]    broken;
  logic [N*CW-1:0] combo_flat;
  logic [7:0]      repair_count;

  int compared = 0;
  int mismatched = 0;

  // Reference model: per-station flags and counts, stepped once per clock.
  bit m_play, m_overdue, m_bad;
  int m_count;
  bit m_armed[N];
  bit m_broken[N];
  int m_arm_ticks[N];
  int m_age[N];
  int m_combo[N];

  vector_t vec[9];

  always #5 Clk = ~Clk;

  nexys_starship_repair_bank #(
    .NUM_STATIONS (N),
    .COMBO_W      (CW),
    .ARM_TICKS    (ARM),
    .REPAIR_TICKS (REP),
    .MAX_BROKEN   (MAXB)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .timer_tick    (timer_tick),
    .play_flag     (play_flag),
    .gameover_ctrl (gameover_ctrl),
    .break_random  (break_random),
    .random_hex    (random_hex),
    .hex_combo     (hex_combo),
    .sel           (sel),
    .submit        (submit),
    .override      (override),
    .q_Init        (q_Init),
    .q_Play        (q_Play),
    .broken        (broken),
    .combo_flat    (combo_flat),
    .overdue       (overdue),
    .bad_try       (bad_try),
    .repair_count  (repair_count)
  );

  function automatic stim_t mk(logic tick, logic play, logic gover, logic [N-1:0] brk,
                               logic [CW-1:0] rhex, logic [CW-1:0] hex, logic [1:0] s,
                               logic sub, logic ovr);
    stim_t r;
    r.tick = tick; r.play = play; r.gover = gover; r.brk = brk;
    r.rhex = rhex; r.hex = hex; r.sel = s; r.sub = sub; r.ovr = ovr;
    return r;
  endfunction

  function automatic logic [N-1:0] modelBroken();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_broken[i];
    return v;
  endfunction

  function automatic logic [N*CW-1:0] modelCombo();
    logic [N*CW-1:0] v;
    for (int i = 0; i < N; i++) v[i*CW +: CW] = CW'(m_combo[i]);
    return v;
  endfunction

  task automatic modelReset();
    m_play = 0; m_overdue = 0; m_bad = 0; m_count = 0;
    for (int i = 0; i < N; i++) begin
      m_armed[i] = 0; m_broken[i] = 0; m_arm_ticks[i] = 0; m_age[i] = 0; m_combo[i] = 0;
    end
  endtask

  task automatic modelStep();
    int nb, g;
    m_bad = 0;
    if (gameover_ctrl) begin
      m_play = 0;
      for (int i = 0; i < N; i++) begin
        m_armed[i] = 0; m_broken[i] = 0; m_arm_ticks[i] = 0; m_age[i] = 0; m_combo[i] = 0;
      end
      return;
    end
    if (!m_play) begin
      if (play_flag) begin
        m_play = 1; m_count = 0; m_overdue = 0;
        for (int i = 0; i < N; i++) m_arm_ticks[i] = 0;
      end
      return;
    end
    nb = 0;
    for (int i = 0; i < N; i++) nb += int'(m_broken[i]);
    g = -1;
    if (nb < MAXB)
      for (int i = 0; i < N; i++)
        if (g < 0 && m_armed[i] && break_random[i]) g = i;
    for (int i = 0; i < N; i++) begin
      if (m_broken[i]) begin
        if (int'(sel) == i && (override || (submit && int'(hex_combo) == m_combo[i]))) begin
          m_broken[i] = 0; m_arm_ticks[i] = 0; m_combo[i] = 0;
          if (m_count < 255) m_count++;
        end else begin
          if (int'(sel) == i && submit) m_bad = 1;
          if (timer_tick && m_age[i] < REP) begin
            m_age[i]++;
            if (m_age[i] == REP) m_overdue = 1;
          end
        end
      end else if (m_armed[i]) begin
        if (i == g) begin
          m_armed[i] = 0; m_broken[i] = 1; m_age[i] = 0; m_combo[i] = int'(random_hex);
        end
      end else if (timer_tick) begin
        m_arm_ticks[i]++;
        if (m_arm_ticks[i] == ARM) m_armed[i] = 1;
      end
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    timer_tick = s.tick; play_flag = s.play; gameover_ctrl = s.gover;
    break_random = s.brk; random_hex = s.rhex; hex_combo = s.hex;
    sel = s.sel; submit = s.sub; override = s.ovr;
    @(posedge Clk);
    modelStep();
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAllModel(input string tag);
    checkOutput({tag, " q_Init"}, 32'(q_Init), 32'(!m_play));
    checkOutput({tag, " q_Play"}, 32'(q_Play), 32'(m_play));
    checkOutput({tag, " broken"}, 32'(broken), 32'(modelBroken()));
    checkOutput({tag, " combo_flat"}, 32'(combo_flat), 32'(modelCombo()));
    checkOutput({tag, " overdue"}, 32'(overdue), 32'(m_overdue));
    checkOutput({tag, " bad_try"}, 32'(bad_try), 32'(m_bad));
    checkOutput({tag, " repair_count"}, 32'(repair_count), 32'(m_count));
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, " q_Init"}, 32'(q_Init), 32'd1);
    checkOutput({tag, " q_Play"}, 32'(q_Play), 32'd0);
    checkOutput({tag, " broken"}, 32'(broken), 32'd0);
    checkOutput({tag, " combo_flat"}, 32'(combo_flat), 32'd0);
    checkOutput({tag, " overdue"}, 32'(overdue), 32'd0);
    checkOutput({tag, " bad_try"}, 32'(bad_try), 32'd0);
    checkOutput({tag, " repair_count"}, 32'(repair_count), 32'd0);
  endtask

  stim_t idle_s, tick_s, play_s;

  initial begin
    idle_s = mk(0, 0, 0, 4'b0000, 4'h0, 4'h0, 2'd0, 0, 0);
    tick_s = mk(1, 0, 0, 4'b0000, 4'h0, 4'h0, 2'd0, 0, 0);
    play_s = mk(0, 1, 0, 4'b0000, 4'h0, 4'h0, 2'd0, 0, 0);

    // Directed table entered with all stations ARMED and no score yet.
    vec[0] = '{mk(0,0,0,4'b0110,4'hA,4'h0,2'd0,0,0), 4'b0010, 16'h00A0, 1'b0, 8'd0};
    vec[1] = '{mk(0,0,0,4'b0110,4'h5,4'h0,2'd0,0,0), 4'b0110, 16'h05A0, 1'b0, 8'd0};
    vec[2] = '{mk(0,0,0,4'b1000,4'h7,4'h0,2'd0,0,0), 4'b0110, 16'h05A0, 1'b0, 8'd0};
    vec[3] = '{mk(0,0,0,4'b1000,4'h7,4'h3,2'd1,1,0), 4'b0110, 16'h05A0, 1'b1, 8'd0};
    vec[4] = '{mk(0,0,0,4'b1000,4'h7,4'hA,2'd1,1,0), 4'b0100, 16'h0500, 1'b0, 8'd1};
    vec[5] = '{mk(0,0,0,4'b1000,4'hC,4'h0,2'd0,0,0), 4'b1100, 16'hC500, 1'b0, 8'd1};
    vec[6] = '{mk(0,0,0,4'b0000,4'h0,4'h0,2'd2,1,1), 4'b1000, 16'hC000, 1'b0, 8'd2};
    vec[7] = '{mk(0,0,0,4'b0000,4'h0,4'hC,2'd3,1,0), 4'b0000, 16'h0000, 1'b0, 8'd3};
    vec[8] = '{mk(0,0,0,4'b0000,4'h0,4'h0,2'd0,0,0), 4'b0000, 16'h0000, 1'b0, 8'd3};

    timer_tick = 0; play_flag = 0; gameover_ctrl = 0; break_random = '0;
    random_hex = '0; hex_combo = '0; sel = '0; submit = 0; override = 0;
    modelReset();
    #12;
    checkCleared("por");
    @(negedge Clk);
    Reset = 1'b1;

    // Asynchronous reset mid-game with station 1 broken.
    applyStimulus(play_s);
    repeat (ARM) applyStimulus(tick_s);
    applyStimulus(mk(0, 0, 0, 4'b0010, 4'h9, 4'h0, 2'd0, 0, 0));
    checkOutput("pre_reset broken", 32'(broken), 32'b0010);
    #3;
    Reset = 1'b0;
    #1;
    checkCleared("async_reset");
    modelReset();
    @(negedge Clk);
    Reset = 1'b1;

    applyStimulus(play_s);
    checkAllModel("play");
    for (int t = 0; t < ARM; t++) begin
      applyStimulus(tick_s);
      checkAllModel("arming");
    end

    for (int k = 0; k < 9; k++) begin
      applyStimulus(vec[k].in);
      checkOutput($sformatf("vec%0d broken", k), 32'(broken), 32'(vec[k].exp_broken));
      checkOutput($sformatf("vec%0d combo_flat", k), 32'(combo_flat), 32'(vec[k].exp_combo));
      checkOutput($sformatf("vec%0d bad_try", k), 32'(bad_try), 32'(vec[k].exp_bad));
      checkOutput($sformatf("vec%0d repair_count", k), 32'(repair_count), 32'(vec[k].exp_count));
    end

    // Correct submit on the very tick that would hit the deadline.
    applyStimulus(mk(0, 0, 0, 4'b0001, 4'h6, 4'h0, 2'd0, 0, 0));
    checkAllModel("brk0");
    for (int t = 0; t < REP - 1; t++) begin
      applyStimulus(tick_s);
      checkAllModel("age");
    end
    checkOutput("age31 overdue", 32'(overdue), 32'd0);
    applyStimulus(mk(1, 0, 0, 4'b0000, 4'h0, 4'h6, 2'd0, 1, 0));
    checkOutput("race broken0", 32'(broken[0]), 32'd0);
    checkOutput("race overdue", 32'(overdue), 32'd0);
    checkOutput("race repair_count", 32'(repair_count), 32'd4);

    // Same again with no repair: overdue rises on the last tick.
    repeat (ARM) applyStimulus(tick_s);
    applyStimulus(mk(0, 0, 0, 4'b0001, 4'h2, 4'h0, 2'd0, 0, 0));
    checkOutput("rebreak broken", 32'(broken), 32'b0001);
    repeat (REP - 1) applyStimulus(tick_s);
    checkOutput("late31 overdue", 32'(overdue), 32'd0);
    applyStimulus(tick_s);
    checkOutput("late32 overdue", 32'(overdue), 32'd1);
    checkOutput("late32 broken0", 32'(broken[0]), 32'd1);
    repeat (5) applyStimulus(tick_s);
    checkAllModel("saturate");

    // Gameover beats override and a break request in the same cycle.
    applyStimulus(mk(0, 0, 1, 4'b1110, 4'h4, 4'h0, 2'd0, 0, 1));
    checkOutput("gover q_Init", 32'(q_Init), 32'd1);
    checkOutput("gover broken", 32'(broken), 32'd0);
    checkOutput("gover combo_flat", 32'(combo_flat), 32'd0);
    checkOutput("gover repair_count", 32'(repair_count), 32'd4);
    checkAllModel("gover");

    applyStimulus(play_s);
    checkAllModel("replay");
    for (int c = 0; c < 1500; c++) begin
      stim_t s;
      s.tick  = ($urandom_range(0, 1) == 0);
      s.play  = ($urandom_range(0, 9) == 0);
      s.gover = ($urandom_range(0, 199) == 0);
      s.brk   = N'($urandom);
      s.rhex  = CW'($urandom);
      s.sel   = 2'($urandom);
      s.hex   = ($urandom_range(0, 1) == 0) ? CW'(m_combo[s.sel]) : CW'($urandom);
      s.sub   = ($urandom_range(0, 3) == 0);
      s.ovr   = ($urandom_range(0, 15) == 0);
      applyStimulus(s);
      checkAllModel("rand");
    end

    applyStimulus(idle_s);
    checkAllModel("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
